ts_gen_mlane: RTL



---
 rtl/ts_gen_mlane.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ts_gen_mlane.sv
// ts_gen_mlane: multi-lane TS1/TS2 ordered-set generator.
// Drives NUM_LANES lanes in lockstep from a single LTSSM state/substate,
// building 16-symbol training sets with per-lane link/lane fields, lane
// reversal, per-lane enable, stop control and a saturating sent-TS counter.
//
// ts_info encoding used here: [7:4] state, [3:0] substate.
//   state POLL = 4'h1 : ACTIVE = 0, CONFIG = 1, others = 2..F
//   state CFG  = 4'h2 : LW_START = 0, LW_ACC = 1, LN_WAIT = 2,
//                       LN_ACC = 3, COMPLETE = 4, IDLE = 5
// mode: 1 = downstream port (DSP), 0 = upstream port (USP).
module ts_gen_mlane #(
  parameter int          NUM_LANES    = 4,
  parameter int          CNT_W        = 16,
  parameter logic [7:0]  LINK_NUM     = 8'h01,
  parameter logic [5:0]  RATE_SUPPORT = 6'h01,
  parameter int          TGT_POLL_ACT = 1024,
  parameter int          TGT_POLL_CFG = 16,
  parameter int          TGT_CFG_GEN  = 16,
  parameter int          TGT_CFG_C2I  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               ts_info,
  input  logic                     ts_update,
  output logic                     ts_update_ack,
  input  logic                     ts_stop,
  input  logic                     mode,
  input  logic [NUM_LANES-1:0]     lane_en,
  input  logic                     lane_rev,
  input  logic [7:0]               rcv_link_num,
  input  logic                     rcv_link_num_vld,
  input  logic [8*NUM_LANES-1:0]   rcv_lane_num,
  input  logic [NUM_LANES-1:0]     rcv_lane_num_vld,
  output logic                     tsa_update_ack,
  output logic                     ts_sent_enough,
  output logic [NUM_LANES-1:0]     ts_valid,
  output logic [128*NUM_LANES-1:0] ts,
  input  logic [NUM_LANES-1:0]     ts_tx_fifo_full
);

  localparam logic [3:0] ST_POLL         = 4'h1;
  localparam logic [3:0] ST_CFG          = 4'h2;
  localparam logic [3:0] SUB_POLL_ACTIVE = 4'h0;
  localparam logic [3:0] SUB_POLL_CFG    = 4'h1;
  localparam logic [3:0] SUB_CFG_LW_STA  = 4'h0;
  localparam logic [3:0] SUB_CFG_LW_ACC  = 4'h1;
  localparam logic [3:0] SUB_CFG_LN_WAIT = 4'h2;
  localparam logic [3:0] SUB_CFG_COMPL   = 4'h4;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] SYM_TS1 = 8'h4A;
  localparam logic [7:0] SYM_TS2 = 8'h45;

  typedef enum logic {IDLE, XMIT} state_e;

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          tgt_q, tgt_d;
  logic [128*NUM_LANES-1:0]  ts_q, ts_d;
  logic [NUM_LANES-1:0]      ts_valid_q;
  logic                      ts_update_ack_q;
  logic                      tsa_update_ack_q;
  logic                      sent_q;

  logic [3:0] st;
  logic [3:0] sub;
  logic       is_dsp;
  logic       tsa_upd;
  logic       host_upd;
  logic       upd_evt;
  logic       stall;

  assign st       = ts_info[7:4];
  assign sub      = ts_info[3:0];
  assign is_dsp   = mode;
  assign tsa_upd  = rcv_link_num_vld | (|rcv_lane_num_vld);
  assign host_upd = ts_update & ~ts_update_ack_q;
  assign upd_evt  = host_upd | tsa_upd;
  assign stall    = |(ts_tx_fifo_full & lane_en);
  assign cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // Reload image: target and per-lane symbols that an update would load.
  always_comb begin
    logic       known;
    logic [7:0] body;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] ln;
    logic [7:0] usp_s1;
    logic [7:0] usp_s2;
    // NOTE: every variable gets a value before any branch, so no latch can form.
    ts_d   = ts_q;
    tgt_d  = {CNT_W{1'b1}};
    known  = 1'b0;
    body   = SYM_TS1;
    usp_s1 = rcv_link_num_vld ? rcv_link_num : SYM_PAD;
    case (st)
      ST_POLL: begin
        known = 1'b1;
        tgt_d = (sub == SUB_POLL_ACTIVE) ? CNT_W'(TGT_POLL_ACT) : CNT_W'(TGT_POLL_CFG);
        body  = (sub == SUB_POLL_CFG) ? SYM_TS2 : SYM_TS1;
      end
      ST_CFG: begin
        known = 1'b1;
        tgt_d = (sub == SUB_CFG_COMPL) ? CNT_W'(TGT_CFG_C2I) : CNT_W'(TGT_CFG_GEN);
        body  = (sub == SUB_CFG_COMPL) ? SYM_TS2 : SYM_TS1;
      end
      default: ;
    endcase
    for (int i = 0; i < NUM_LANES; i++) begin
      s1     = ts_q[128*i+112 +: 8];
      s2     = ts_q[128*i+104 +: 8];
      ln     = lane_rev ? 8'(NUM_LANES - 1 - i) : 8'(i);
      usp_s2 = rcv_lane_num_vld[i] ? rcv_lane_num[8*i +: 8] : SYM_PAD;
      if (st == ST_POLL) begin
        s1 = SYM_PAD;
        s2 = SYM_PAD;
      end else if (st == ST_CFG) begin
        case (sub)
          SUB_CFG_LW_STA: begin
            s1 = is_dsp ? LINK_NUM : SYM_PAD;
            s2 = SYM_PAD;
          end
          SUB_CFG_LW_ACC: begin
            s1 = is_dsp ? LINK_NUM : usp_s1;
            s2 = is_dsp ? ln : usp_s2;
          end
          SUB_CFG_LN_WAIT: begin
            if (!is_dsp) begin
              s1 = LINK_NUM;
              s2 = usp_s2;
            end
          end
          default: ;
        endcase
      end
      if (!lane_en[i]) begin
        s1 = SYM_PAD;
        s2 = SYM_PAD;
      end
      if (known) begin
        ts_d[128*i +: 128] = {SYM_COM, s1, s2, 8'hFF, {2'b00, RATE_SUPPORT}, 8'h00,
                              {10{body}}};
      end
    end
  end

  // Control FSM with registered beats, acks, counter and symbol store.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      tgt_q            <= '0;
      // NOTE: the symbol store is ordinary flops, not a RAM, so it is cleared with the rest.
      ts_q             <= '0;
      ts_valid_q       <= '0;
      ts_update_ack_q  <= 1'b0;
      tsa_update_ack_q <= 1'b0;
      sent_q           <= 1'b0;
    end else if (ts_stop) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      ts_valid_q       <= '0;
      ts_update_ack_q  <= 1'b0;
      tsa_update_ack_q <= 1'b0;
      sent_q           <= 1'b0;
    end else if (upd_evt) begin
      state_q          <= XMIT;
      ts_q             <= ts_d;
      tgt_q            <= tgt_d;
      cnt_q            <= '0;
      ts_valid_q       <= '0;
      ts_update_ack_q  <= host_upd;
      tsa_update_ack_q <= tsa_upd;
      sent_q           <= 1'b0;
    end else begin
      ts_update_ack_q  <= 1'b0;
      tsa_update_ack_q <= 1'b0;
      if (state_q == XMIT) begin
        if (cnt_q >= tgt_q) sent_q <= 1'b1;
        if (!stall) begin
          ts_valid_q <= lane_en;
          cnt_q      <= cnt_d;
        end else begin
          ts_valid_q <= '0;
        end
      end else begin
        ts_valid_q <= '0;
      end
    end
  end

  assign ts_update_ack  = ts_update_ack_q;
  assign tsa_update_ack = tsa_update_ack_q;
  assign ts_sent_enough = sent_q;
  assign ts_valid       = ts_valid_q;
  assign ts             = ts_q;

endmodule
